vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
// - Parametrised VGA timing and pixel-output stage. Successor to the fixed 640x480 / 6-bit VGA top.
// - Generates h/v counters and pixel coordinates for the upstream pixel source.
// - Blanks and registers returned colour data, aligned with h_sync and v_sync.
// - Adds configurable timing, sync polarity, colour depth, source latency and frame/line strobes.
// PARAMETERS
// - H_ACTIVE 640 : visible pixels per line
// - H_FRONT 16 : horizontal front porch, in pixels
// - H_SYNC 96 : horizontal sync width, in pixels
// - H_BACK 48 : horizontal back porch, in pixels
// - V_ACTIVE 480 : visible lines per frame
// - V_FRONT 10 : vertical front porch, in lines
// - V_SYNC 2 : vertical sync width, in lines
// - V_BACK 33 : vertical back porch, in lines
// - H_POL 0 : h_sync active level (0 = active-low)
// - V_POL 0 : v_sync active level (0 = active-low)
// - COLOR_BITS 2 : bits per colour channel (R, G, B)
// - PIPE_LAT 1 : pixel-source latency in cycles, >= 1
// PORTS
// - pixel_clk in 1 : pixel clock; all logic on its rising edge
// - reset in 1 : synchronous, active-high reset
// - color_data in 3*COLOR_BITS : {R,G,B} from the pixel source, MSB = R
// - pixel_x out HW : horizontal counter, HW = $clog2(H_TOTAL)
// - pixel_y out VW : vertical counter, VW = $clog2(V_TOTAL)
// - line_start out 1 : one-cycle pulse when pixel_x == 0
// - frame_start out 1 : one-cycle pulse when pixel_x == 0 and pixel_y == 0
// - h_sync out 1 : horizontal sync, polarity set by H_POL
// - v_sync out 1 : vertical sync, polarity set by V_POL
// - display_on out 1 : high when rgb carries a visible pixel
// - rgb out 3*COLOR_BITS : blanked colour output
// BEHAVIOUR
// - Totals: H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK; V_TOTAL likewise. Defaults give 800 x 525.
// - Region order within a line or frame: active, front porch, sync, back porch.
// - Reset: while reset = 1, at each edge:
//   - h_cnt = v_cnt = 0.
//   - All delay stages clear to the blank state.
//   - h_sync = ~H_POL, v_sync = ~V_POL, display_on = 0, rgb = 0.
// - Reset is honoured mid-frame: the next cycle after release restarts at pixel (0,0) with frame_start = 1.
// - Counters:
//   - h_cnt increments every cycle and wraps H_TOTAL-1 -> 0.
//   - v_cnt increments only on the h wrap, and wraps V_TOTAL-1 -> 0 when both counters are at their maximum.
//   - pixel_x = h_cnt and pixel_y = v_cnt, driven directly from the registers (no extra latency).
//   - line_start and frame_start are decoded combinationally from the counter registers.
// - Sync and enable decode, from the counters:
//   - hs_raw when H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC.
//   - vs_raw on the same rule using the V parameters.
//   - de_raw = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
// - Alignment:
//   - Source contract: coordinates presented in cycle c have their color_data valid in cycle c+PIPE_LAT-1.
//   - PIPE_LAT = 1 therefore means a combinational source.
//   - hs_raw, vs_raw and de_raw pass through a PIPE_LAT-1 stage delay line, then a final output register.
//   - The final register loads rgb = de_delayed ? color_data : 0.
//   - Result: h_sync, v_sync, display_on and rgb for the pixel at cycle c appear together in cycle c+PIPE_LAT.
// - Output levels: h_sync = hs_delayed ? H_POL : ~H_POL; v_sync likewise with V_POL.
// - Blanking: rgb is forced to 0 whenever display_on = 0, regardless of color_data.
// - No handshake: the source must always meet the latency contract.
// STRUCTURE
// - vga_pkg holds:
//   - the default 640x480@60 timing constants;
//   - a function for H_TOTAL / V_TOTAL;
//   - a localparam helper for counter widths.
// - Sub-module vga_delay_line (params WIDTH, DEPTH; DEPTH = 0 is a pass-through) carries {hs, vs, de}.
// - Everything else stays in vga_sync_gen: counters, decode, output register.
// TESTING
// - Reset held 5 cycles, then released, defaults:
//   - during reset: h_sync = 1, v_sync = 1, rgb = 0;
//   - first cycle after release: pixel_x = 0, pixel_y = 0, frame_start = 1.
// - Full frame, defaults, color_data = 6'b110000:
//   - 420000 cycles per frame; 307200 display_on cycles, each with rgb = 110000;
//   - h_sync low for 96 cycles per line, with output pixel_x-1 in 656..751;
//   - v_sync low exactly for lines 490..491 (1600 cycles).
// - PIPE_LAT = 3, source = registered 2-cycle echo of pixel_x[5:0]:
//   - on every visible cycle, rgb equals the pixel_x captured 3 cycles earlier;
//   - first visible rgb appears 3 cycles after frame_start.
// - H_POL = 1, V_POL = 1, with a small custom timing (8/2/2/2 x 4/1/1/1):
//   - sync pulses are active-high and 2 cycles / 1 line wide;
//   - line period 14 cycles, frame period 98 cycles.
// - Reset asserted at pixel (300,200) for 1 cycle:
//   - next cycle: pixel (0,0), frame_start = 1;
//   - no partial sync pulse on the outputs.
// - color_data = all ones held constant: rgb = 0 whenever display_on = 0, across all porch and sync regions.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants, control-bundle type and sizing helpers
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vga_ctl_t;
  function automatic int vga_total(input int active, input int front, input int sync, input int back);
    return active + front + sync + back;
  endfunction
  function automatic int cnt_w(input int total);
    return total > 1 ? $clog2(total) : 1;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage register delay cleared to zero on reset; DEPTH = 0 passes straight through
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    always_ff @(posedge clk) begin
      if (rst) stage_q <= '{default: '0};
      else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end
    assign q_o = stage_q[DEPTH-1];
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA timing counters with latency-aligned, blanked colour output
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int COLOR_BITS = 2,
  parameter int PIPE_LAT   = 1,
  localparam int H_TOTAL   = vga_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK),
  localparam int V_TOTAL   = vga_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK),
  localparam int HW        = cnt_w(H_TOTAL),
  localparam int VW        = cnt_w(V_TOTAL),
  localparam int CW        = 3 * COLOR_BITS
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic [CW-1:0] color_data,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          h_sync,
  output logic          v_sync,
  output logic          display_on,
  output logic [CW-1:0] rgb
);
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_end, v_end;
  vga_ctl_t      raw, dly;
  logic          h_sync_q, v_sync_q, de_q;
  logic [CW-1:0] rgb_q;
  always_comb begin
    h_end   = int'(h_cnt_q) == H_TOTAL - 1;
    v_end   = int'(v_cnt_q) == V_TOTAL - 1;
    h_cnt_d = h_end ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = !h_end ? v_cnt_q : v_end ? '0 : v_cnt_q + 1'b1;
    raw.hs  = int'(h_cnt_q) >= H_ACTIVE + H_FRONT && int'(h_cnt_q) < H_ACTIVE + H_FRONT + H_SYNC;
    raw.vs  = int'(v_cnt_q) >= V_ACTIVE + V_FRONT && int'(v_cnt_q) < V_ACTIVE + V_FRONT + V_SYNC;
    raw.de  = int'(h_cnt_q) < H_ACTIVE && int'(v_cnt_q) < V_ACTIVE;
  end
  // Sync/enable wait PIPE_LAT-1 cycles so the final register meets the source's colour
  vga_delay_line #(.WIDTH($bits(vga_ctl_t)), .DEPTH(PIPE_LAT - 1)) u_dly (
    .clk(pixel_clk),
    .rst(reset),
    .d_i(raw),
    .q_o(dly)
  );
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      h_sync_q <= ~H_POL;
      v_sync_q <= ~V_POL;
      de_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      h_sync_q <= dly.hs ? H_POL : ~H_POL;
      v_sync_q <= dly.vs ? V_POL : ~V_POL;
      de_q     <= dly.de;
      rgb_q    <= dly.de ? color_data : '0;
    end
  end
  assign pixel_x     = h_cnt_q;
  assign pixel_y     = v_cnt_q;
  assign line_start  = h_cnt_q == '0;
  assign frame_start = line_start && v_cnt_q == '0;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign display_on  = de_q;
  assign rgb         = rgb_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: default timing vectors, latency-3 echo source and a small active-high
// timing checked cycle by cycle against an arithmetic frame model under random resets
module tb_vga_sync_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // Default timing, combinational source
  logic rst0 = 1'b1;
  logic [5:0] col0 = '0;
  logic [9:0] x0, y0;
  logic ls0, fs0, hs0, vs0, de0;
  logic [5:0] rgb0;
  vga_sync_gen u0 (
    .pixel_clk(clk), .reset(rst0), .color_data(col0), .pixel_x(x0), .pixel_y(y0),
    .line_start(ls0), .frame_start(fs0), .h_sync(hs0), .v_sync(vs0), .display_on(de0), .rgb(rgb0)
  );
  // Default timing, PIPE_LAT = 3 with a registered 2-cycle echo of pixel_x
  logic [9:0] x1, y1;
  logic ls1, fs1, hs1, vs1, de1;
  logic [5:0] rgb1;
  logic [5:0] e1_q = '0, e2_q = '0;
  always @(posedge clk) begin
    e1_q <= x1[5:0];
    e2_q <= e1_q;
  end
  vga_sync_gen #(.PIPE_LAT(3)) u1 (
    .pixel_clk(clk), .reset(rst0), .color_data(e2_q), .pixel_x(x1), .pixel_y(y1),
    .line_start(ls1), .frame_start(fs1), .h_sync(hs1), .v_sync(vs1), .display_on(de1), .rgb(rgb1)
  );
  // Small custom timing 14 x 7, active-high syncs, PIPE_LAT = 2
  logic rst2 = 1'b1;
  logic [5:0] col2 = '0;
  logic [3:0] x2;
  logic [2:0] y2;
  logic ls2, fs2, hs2, vs2, de2;
  logic [5:0] rgb2;
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1), .PIPE_LAT(2)
  ) u2 (
    .pixel_clk(clk), .reset(rst2), .color_data(col2), .pixel_x(x2), .pixel_y(y2),
    .line_start(ls2), .frame_start(fs2), .h_sync(hs2), .v_sync(vs2), .display_on(de2), .rgb(rgb2)
  );
  // Echo monitor: every visible rgb must be pixel_x from three cycles earlier
  bit en1 = 0, seen1 = 0;
  int n1 = 0, fs1_at = 0;
  logic [5:0] xh [3] = '{default: '0};
  always @(negedge clk) if (en1) begin
    n1++;
    if (fs1) fs1_at = n1;
    if (de1) begin
      chk("echo_rgb", rgb1, xh[2]);
      if (!seen1) begin
        seen1 = 1;
        chk("echo_first_visible_lag", n1 - fs1_at, 3);
      end
    end
    xh[2] = xh[1];
    xh[1] = xh[0];
    xh[0] = x1[5:0];
  end
  typedef struct {
    int adv;
    logic [5:0] col;
    int x, y;
    logic ls, fs, hs, de;
    logic [5:0] rgb;
  } vec_t;
  vec_t vec [9];
  localparam int N2 = 2400;
  initial begin
    vec[0] = '{1,   6'h30, 1,   0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h30};
    vec[1] = '{639, 6'h0c, 640, 0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h0c};
    vec[2] = '{1,   6'h3f, 641, 0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00};
    vec[3] = '{15,  6'h3f, 656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00};
    vec[4] = '{1,   6'h3f, 657, 0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00};
    vec[5] = '{95,  6'h15, 752, 0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00};
    vec[6] = '{1,   6'h15, 753, 0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00};
    vec[7] = '{47,  6'h2a, 0,   1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h00};
    vec[8] = '{1,   6'h2a, 1,   1, 1'b0, 1'b0, 1'b1, 1'b1, 6'h2a};
    fork
      begin : seq0
        int lows;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("rst_hsync", hs0, 1);
          chk("rst_vsync", vs0, 1);
          chk("rst_rgb", rgb0, 0);
          chk("rst_display_on", de0, 0);
        end
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        en1 = 1;
        @(negedge clk);
        chk("release_pos", {x0, y0}, 0);
        chk("release_strobes", {ls0, fs0}, 2'b11);
        for (int i = 0; i < 9; i++) begin
          col0 = vec[i].col;
          repeat (vec[i].adv) @(negedge clk);
          chk($sformatf("vec%0d_pos", i), {x0, y0}, {10'(vec[i].x), 10'(vec[i].y)});
          chk($sformatf("vec%0d_strobes", i), {ls0, fs0}, {vec[i].ls, vec[i].fs});
          chk($sformatf("vec%0d_out", i), {hs0, vs0, de0, rgb0}, {vec[i].hs, 1'b1, vec[i].de, vec[i].rgb});
        end
        repeat (699) @(negedge clk);
        chk("pre_reset_pos", {x0, y0}, {10'd700, 10'd1});
        chk("pre_reset_in_hsync", hs0, 0);
        en1 = 0;
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        chk("mid_reset_pos", {x0, y0}, 0);
        chk("mid_reset_frame_start", fs0, 1);
        chk("mid_reset_out", {hs0, vs0, de0, rgb0}, {3'b110, 6'h00});
        lows = 0;
        repeat (656) begin
          @(negedge clk);
          lows += int'(!hs0);
        end
        chk("post_reset_no_partial_hsync", lows, 0);
        @(negedge clk);
        chk("post_reset_hsync_resumes", hs0, 0);
        chk("echo_seen_visible", seen1, 1);
      end
      begin : seq2
        int p, q, qx, qy, ex, ey;
        int hs_n, vs_n, de_n, leak, hs_rise, vs_rise;
        bit ok, hs_prev, vs_prev;
        logic eh, ev, ed;
        logic [5:0] er;
        bit hist_r [N2];
        int hist_p [N2];
        logic [5:0] hist_c [N2];
        p = 0; hs_n = 0; vs_n = 0; de_n = 0; leak = 0; hs_rise = -1; vs_rise = -1;
        hs_prev = 0; vs_prev = 0;
        for (int n = 0; n < N2; n++) begin
          @(negedge clk);
          // Output at cycle n shows pixel n-2 unless either of the last two edges was a reset
          ok = n >= 2 && !hist_r[n-1] && !hist_r[n-2];
          ex = p % 14;
          ey = (p / 14) % 7;
          eh = 0; ev = 0; ed = 0; er = '0;
          if (ok) begin
            q = hist_p[n-2];
            qx = q % 14;
            qy = (q / 14) % 7;
            eh = qx >= 10 && qx < 12;
            ev = qy == 5;
            ed = qx < 8 && qy < 4;
            er = ed ? hist_c[n-1] : 6'h00;
          end
          chk("small_cycle", {x2, y2, ls2, fs2, hs2, vs2, de2, rgb2},
              {ex[3:0], ey[2:0], ex == 0, p % 98 == 0, eh, ev, ed, er});
          if (n >= 120 && n < 218) begin
            hs_n += int'(hs2);
            vs_n += int'(vs2);
            de_n += int'(de2);
            leak += int'(!de2 && rgb2 != 0);
          end
          if (n >= 120 && n < 400) begin
            if (hs2 && !hs_prev) begin
              if (hs_rise >= 0) chk("small_line_period", n - hs_rise, 14);
              hs_rise = n;
            end
            if (vs2 && !vs_prev) begin
              if (vs_rise >= 0) chk("small_frame_period", n - vs_rise, 98);
              vs_rise = n;
            end
          end
          hs_prev = hs2;
          vs_prev = vs2;
          rst2 = n < 3 ? 1'b1 : n < 400 ? 1'b0 : $urandom_range(0, 39) == 0;
          col2 = (n >= 100 && n < 300) ? 6'h3f : 6'($urandom);
          hist_r[n] = rst2;
          hist_c[n] = col2;
          hist_p[n] = p;
          p = rst2 ? 0 : p + 1;
        end
        chk("small_hsync_cycles_per_frame", hs_n, 14);
        chk("small_vsync_cycles_per_frame", vs_n, 14);
        chk("small_display_cycles_per_frame", de_n, 32);
        chk("small_blanking_leak", leak, 0);
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
